// File: rtl/alu_pkg.sv
// Shared ALU control-code definitions for the execute stage.
// Also holds the small decode helpers used by the core and the stage.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_NOR = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_BEQ = 4'b0110;
    localparam logic [3:0] ALU_BNE = 4'b0111;

    // Every code from here upward is unassigned.
    localparam logic [3:0] ALU_ILLEGAL_MIN = 4'b1000;

    function automatic logic is_branch(input logic [3:0] code);
        return (code == ALU_BEQ) || (code == ALU_BNE);
    endfunction

    function automatic logic is_illegal(input logic [3:0] code);
        return (code >= ALU_ILLEGAL_MIN);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result, zero flag, signed overflow (ADD/SUB only)
// and an illegal-code flag. Illegal codes produce a zero result.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] result_s;
    logic             ovf_s;
    logic             slt_s;

    assign sum_s  = op_a + op_b;
    assign diff_s = op_a - op_b;
    assign slt_s  = ($signed(op_a) < $signed(op_b));

    // Operation select and signed-overflow detection.
    always_comb begin
        result_s = '0;
        ovf_s    = 1'b0;
        case (alu_ctrl)
            ALU_ADD: begin
                result_s = sum_s;
                ovf_s    = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_s[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_SUB: begin
                result_s = diff_s;
                ovf_s    = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff_s[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_AND: result_s = op_a & op_b;
            ALU_NOR: result_s = ~(op_a | op_b);
            ALU_OR:  result_s = op_a | op_b;
            ALU_SLT: result_s = {{(WIDTH-1){1'b0}}, slt_s};
            ALU_BEQ, ALU_BNE: result_s = diff_s;
            default: begin
                result_s = '0;
                ovf_s    = 1'b0;
            end
        endcase
    end

    assign result   = result_s;
    assign zero     = (result_s == '0);
    assign overflow = ovf_s;
    assign illegal  = is_illegal(alu_ctrl);

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: ALU plus EX/MEM pipeline register with flush/stall,
// one-cycle branch/illegal pulses and saturating performance counters.
module ex_alu_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] store_data_in,
    input  logic [4:0]       rd_in,
    input  logic             reg_write_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic [31:0]      branch_target_in,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] store_data_out,
    output logic [4:0]       rd_out,
    output logic             reg_write_out,
    output logic             mem_read_out,
    output logic             mem_write_out,
    output logic             zero_out,
    output logic             overflow_out,
    output logic             branch_taken,
    output logic [31:0]      branch_target_out,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] branch_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] alu_res_s;
    logic             alu_zero_s;
    logic             alu_ovf_s;
    logic             alu_ill_s;
    logic             bubble_s;
    logic             taken_s;
    logic             ctrl_ok_s;

    logic             valid_d,  valid_q;
    logic [WIDTH-1:0] result_d, result_q;
    logic [WIDTH-1:0] store_d,  store_q;
    logic [4:0]       rd_d,     rd_q;
    logic             rw_d,     rw_q;
    logic             mr_d,     mr_q;
    logic             mw_d,     mw_q;
    logic             zero_d,   zero_q;
    logic             ovf_d,    ovf_q;
    logic             bt_d,     bt_q;
    logic [31:0]      tgt_d,    tgt_q;
    logic             ill_d,    ill_q;
    logic [CNT_W-1:0] icnt_d,   icnt_q;
    logic [CNT_W-1:0] bcnt_d,   bcnt_q;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .alu_ctrl (alu_ctrl),
        .op_a     (op_a),
        .op_b     (op_b),
        .result   (alu_res_s),
        .zero     (alu_zero_s),
        .overflow (alu_ovf_s),
        .illegal  (alu_ill_s)
    );

    // Flush wins over stall; an empty slot with no stall is also a bubble.
    assign bubble_s  = flush || (!stall && !in_valid);
    assign taken_s   = (alu_ctrl == ALU_BEQ) ? alu_zero_s :
                       (alu_ctrl == ALU_BNE) ? !alu_zero_s : 1'b0;
    assign ctrl_ok_s = !is_branch(alu_ctrl) && !alu_ill_s;

    // Next-state for the EX/MEM register and counters.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        store_d  = store_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        mr_d     = mr_q;
        mw_d     = mw_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        tgt_d    = tgt_q;
        bt_d     = 1'b0;
        ill_d    = 1'b0;
        icnt_d   = icnt_q;
        bcnt_d   = bcnt_q;
        if (bubble_s) begin
            valid_d  = 1'b0;
            result_d = '0;
            store_d  = '0;
            rd_d     = 5'd0;
            rw_d     = 1'b0;
            mr_d     = 1'b0;
            mw_d     = 1'b0;
            zero_d   = 1'b0;
            ovf_d    = 1'b0;
            tgt_d    = 32'd0;
        end else if (stall) begin
            valid_d = valid_q;
        end else begin
            valid_d  = 1'b1;
            result_d = alu_res_s;
            store_d  = store_data_in;
            rd_d     = rd_in;
            rw_d     = reg_write_in && ctrl_ok_s;
            mr_d     = mem_read_in && ctrl_ok_s;
            mw_d     = mem_write_in && ctrl_ok_s;
            zero_d   = alu_zero_s;
            ovf_d    = alu_ovf_s;
            bt_d     = taken_s;
            tgt_d    = taken_s ? branch_target_in : 32'd0;
            ill_d    = alu_ill_s;
            if (icnt_q != '1) begin
                icnt_d = icnt_q + CNT_ONE;
            end else begin
                icnt_d = icnt_q;
            end
            if (taken_s && (bcnt_q != '1)) begin
                bcnt_d = bcnt_q + CNT_ONE;
            end else begin
                bcnt_d = bcnt_q;
            end
        end
    end

    // EX/MEM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            store_q  <= '0;
            rd_q     <= 5'd0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            bt_q     <= 1'b0;
            tgt_q    <= 32'd0;
            ill_q    <= 1'b0;
            icnt_q   <= '0;
            bcnt_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            store_q  <= store_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            bt_q     <= bt_d;
            tgt_q    <= tgt_d;
            ill_q    <= ill_d;
            icnt_q   <= icnt_d;
            bcnt_q   <= bcnt_d;
        end
    end

    assign out_valid         = valid_q;
    assign result            = result_q;
    assign store_data_out    = store_q;
    assign rd_out            = rd_q;
    assign reg_write_out     = rw_q;
    assign mem_read_out      = mr_q;
    assign mem_write_out     = mw_q;
    assign zero_out          = zero_q;
    assign overflow_out      = ovf_q;
    assign branch_taken      = bt_q;
    assign branch_target_out = tgt_q;
    assign illegal_op        = ill_q;
    assign instr_count       = instr_count_w(icnt_q);
    assign branch_count      = bcnt_q;

    function automatic logic [CNT_W-1:0] instr_count_w(input logic [CNT_W-1:0] v);
        return v;
    endfunction

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed bench for ex_alu_stage; counters are built 4 bits wide so
// saturation is reachable in a handful of captures.
module tb_ex_alu_stage;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a, op_b, store_data_in;
    logic [4:0]       rd_in;
    logic             reg_write_in, mem_read_in, mem_write_in;
    logic [31:0]      branch_target_in;
    logic             stall, flush;
    logic             out_valid;
    logic [WIDTH-1:0] result, store_data_out;
    logic [4:0]       rd_out;
    logic             reg_write_out, mem_read_out, mem_write_out;
    logic             zero_out, overflow_out, branch_taken, illegal_op;
    logic [31:0]      branch_target_out;
    logic [CNT_W-1:0] instr_count, branch_count;

    int errors = 0;
    int checks = 0;

    ex_alu_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_ctrl(alu_ctrl),
        .op_a(op_a), .op_b(op_b), .store_data_in(store_data_in), .rd_in(rd_in),
        .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .branch_target_in(branch_target_in), .stall(stall), .flush(flush),
        .out_valid(out_valid), .result(result), .store_data_out(store_data_out),
        .rd_out(rd_out), .reg_write_out(reg_write_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .zero_out(zero_out), .overflow_out(overflow_out),
        .branch_taken(branch_taken), .branch_target_out(branch_target_out),
        .illegal_op(illegal_op), .instr_count(instr_count), .branch_count(branch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic rw);
        in_valid = v; alu_ctrl = c; op_a = a; op_b = b; rd_in = rd; reg_write_in = rw;
        store_data_in = a ^ 32'h5A5A_0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        mem_read_in = 1'b0; mem_write_in = 1'b0; branch_target_in = 32'd0;
        drive(1'b1, 4'b0000, 32'd1, 32'd2, 5'd1, 1'b1);
        step(); step();
        checks++; if ({out_valid, reg_write_out, branch_taken, illegal_op, zero_out, overflow_out} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b want 000000", {out_valid, reg_write_out, branch_taken, illegal_op, zero_out, overflow_out}); end
        checks++; if (result !== 32'd0 || instr_count !== 4'd0 || branch_count !== 4'd0) begin errors++; $display("FAIL reset_data: result=%h ic=%0d bc=%0d want 0", result, instr_count, branch_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        drive(1'b1, 4'b0000, 32'h7FFF_FFFF, 32'd1, 5'd3, 1'b1);
        step();
        checks++; if (result !== 32'h8000_0000 || overflow_out !== 1'b1 || zero_out !== 1'b0) begin errors++; $display("FAIL add_ovf: result=%h ovf=%b z=%b want 80000000 1 0", result, overflow_out, zero_out); end
        checks++; if (instr_count !== 4'd1 || out_valid !== 1'b1 || rd_out !== 5'd3 || reg_write_out !== 1'b1) begin errors++; $display("FAIL add_ctl: ic=%0d v=%b rd=%0d rw=%b want 1 1 3 1", instr_count, out_valid, rd_out, reg_write_out); end
        checks++; if (store_data_out !== 32'h25A5_FFFF) begin errors++; $display("FAIL add_store: got %h want 25a5ffff", store_data_out); end
        drive(1'b1, 4'b0101, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1);
        step();
        checks++; if (result !== 32'd1 || overflow_out !== 1'b0) begin errors++; $display("FAIL slt: result=%h ovf=%b want 1 0", result, overflow_out); end
        drive(1'b1, 4'b0001, 32'd5, 32'd5, 5'd5, 1'b1);
        step();
        checks++; if (result !== 32'd0 || zero_out !== 1'b1 || overflow_out !== 1'b0) begin errors++; $display("FAIL sub_eq: result=%h z=%b ovf=%b want 0 1 0", result, zero_out, overflow_out); end
        drive(1'b1, 4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd6, 1'b1);
        step();
        checks++; if (result !== 32'h00F0_00F0) begin errors++; $display("FAIL and: got %h want 00f000f0", result); end
        drive(1'b1, 4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd6, 1'b1);
        step();
        checks++; if (result !== 32'hFFF0_FFF0) begin errors++; $display("FAIL or: got %h want fff0fff0", result); end
        drive(1'b1, 4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd6, 1'b1);
        step();
        checks++; if (result !== 32'h000F_000F) begin errors++; $display("FAIL nor: got %h want 000f000f", result); end
        drive(1'b1, 4'b0001, 32'h8000_0000, 32'd1, 5'd7, 1'b1);
        step();
        checks++; if (result !== 32'h7FFF_FFFF || overflow_out !== 1'b1 || instr_count !== 4'd7) begin errors++; $display("FAIL sub_ovf: result=%h ovf=%b ic=%0d want 7fffffff 1 7", result, overflow_out, instr_count); end
    endtask

    task automatic test_branch_stall();
        drive(1'b1, 4'b0110, 32'h10, 32'h10, 5'd9, 1'b1);
        branch_target_in = 32'h400;
        step();
        checks++; if (branch_taken !== 1'b1 || branch_target_out !== 32'h400 || reg_write_out !== 1'b0) begin errors++; $display("FAIL beq_taken: bt=%b tgt=%h rw=%b want 1 400 0", branch_taken, branch_target_out, reg_write_out); end
        checks++; if (branch_count !== 4'd1 || instr_count !== 4'd8) begin errors++; $display("FAIL beq_cnt: bc=%0d ic=%0d want 1 8", branch_count, instr_count); end
        stall = 1'b1;
        drive(1'b1, 4'b0000, 32'd1, 32'd1, 5'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (branch_taken !== 1'b0 || out_valid !== 1'b1 || rd_out !== 5'd9 || result !== 32'd0) begin errors++; $display("FAIL stall_hold%0d: bt=%b v=%b rd=%0d res=%h want 0 1 9 0", i, branch_taken, out_valid, rd_out, result); end
            checks++; if (branch_count !== 4'd1 || instr_count !== 4'd8) begin errors++; $display("FAIL stall_cnt%0d: bc=%0d ic=%0d want 1 8", i, branch_count, instr_count); end
        end
        stall = 1'b0;
        drive(1'b1, 4'b0111, 32'h10, 32'h10, 5'd9, 1'b1);
        step();
        checks++; if (branch_taken !== 1'b0 || branch_target_out !== 32'd0 || zero_out !== 1'b1 || instr_count !== 4'd9) begin errors++; $display("FAIL bne_not: bt=%b tgt=%h z=%b ic=%0d want 0 0 1 9", branch_taken, branch_target_out, zero_out, instr_count); end
        drive(1'b1, 4'b0111, 32'd1, 32'd2, 5'd9, 1'b1);
        step();
        checks++; if (branch_taken !== 1'b1 || result !== 32'hFFFF_FFFF || branch_count !== 4'd2) begin errors++; $display("FAIL bne_taken: bt=%b res=%h bc=%0d want 1 ffffffff 2", branch_taken, result, branch_count); end
        drive(1'b1, 4'b0000, 32'd1, 32'd1, 5'd2, 1'b1);
        step();
        checks++; if (branch_taken !== 1'b0 || result !== 32'd2 || instr_count !== 4'd11) begin errors++; $display("FAIL pulse_end: bt=%b res=%h ic=%0d want 0 2 11", branch_taken, result, instr_count); end
    endtask

    task automatic test_flush_illegal();
        flush = 1'b1; stall = 1'b1;
        drive(1'b1, 4'b0000, 32'd3, 32'd4, 5'd8, 1'b1);
        step();
        checks++; if (out_valid !== 1'b0 || reg_write_out !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0) begin errors++; $display("FAIL flush: v=%b rw=%b res=%h rd=%0d want 0 0 0 0", out_valid, reg_write_out, result, rd_out); end
        checks++; if (instr_count !== 4'd11 || branch_count !== 4'd2) begin errors++; $display("FAIL flush_cnt: ic=%0d bc=%0d want 11 2", instr_count, branch_count); end
        flush = 1'b0; stall = 1'b0;
        drive(1'b0, 4'b0000, 32'd3, 32'd4, 5'd8, 1'b1);
        step();
        checks++; if (out_valid !== 1'b0 || instr_count !== 4'd11) begin errors++; $display("FAIL bubble: v=%b ic=%0d want 0 11", out_valid, instr_count); end
        drive(1'b1, 4'b1010, 32'd3, 32'd4, 5'd8, 1'b1);
        mem_write_in = 1'b1;
        step();
        checks++; if (illegal_op !== 1'b1 || result !== 32'd0 || reg_write_out !== 1'b0 || mem_write_out !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL illegal: ill=%b res=%h rw=%b mw=%b v=%b want 1 0 0 0 1", illegal_op, result, reg_write_out, mem_write_out, out_valid); end
        drive(1'b1, 4'b0000, 32'd3, 32'd4, 5'd8, 1'b1);
        step();
        checks++; if (illegal_op !== 1'b0 || mem_write_out !== 1'b1 || result !== 32'd7 || instr_count !== 4'd13) begin errors++; $display("FAIL illegal_end: ill=%b mw=%b res=%h ic=%0d want 0 1 7 13", illegal_op, mem_write_out, result, instr_count); end
        mem_write_in = 1'b0;
    endtask

    task automatic test_async_reset();
        drive(1'b1, 4'b0110, 32'h20, 32'h20, 5'd1, 1'b0);
        branch_target_in = 32'h800;
        step();
        checks++; if (branch_taken !== 1'b1 || branch_count !== 4'd3) begin errors++; $display("FAIL pre_reset: bt=%b bc=%0d want 1 3", branch_taken, branch_count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, branch_taken, zero_out, branch_target_out, result, instr_count, branch_count} !== '0) begin errors++; $display("FAIL async_reset: v=%b bt=%b z=%b tgt=%h res=%h ic=%0d bc=%0d want all 0", out_valid, branch_taken, zero_out, branch_target_out, result, instr_count, branch_count); end
        step();
        rst_n = 1'b1;
        drive(1'b1, 4'b0000, 32'd2, 32'd3, 5'd4, 1'b1);
        step();
        checks++; if (result !== 32'd5 || out_valid !== 1'b1 || instr_count !== 4'd1 || branch_count !== 4'd0) begin errors++; $display("FAIL post_reset: res=%h v=%b ic=%0d bc=%0d want 5 1 1 0", result, out_valid, instr_count, branch_count); end
    endtask

    task automatic test_saturation();
        drive(1'b1, 4'b0000, 32'd1, 32'd1, 5'd1, 1'b1);
        for (int i = 0; i < 14; i++) step();
        checks++; if (instr_count !== 4'hF) begin errors++; $display("FAIL sat_reach: ic=%0d want 15", instr_count); end
        step();
        checks++; if (instr_count !== 4'hF || out_valid !== 1'b1) begin errors++; $display("FAIL sat_hold: ic=%0d v=%b want 15 1", instr_count, out_valid); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_branch_stall();
        test_flush_illegal();
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_alu_stage.md
Name: ex_alu_stage

Overview:
Execute stage of the pipelined datapath. Consumes the 4-bit ALU control code produced by the ALU control unit, plus ID/EX operands and control bits. Computes the ALU result, resolves BEQ/BNE, and registers everything into the EX/MEM pipeline register. Supports stall and flush from the hazard unit and keeps saturating performance counters.

Parameters:
WIDTH, 32, datapath width of operands and result
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ID/EX slot holds a real instruction
alu_ctrl  in  4  0000 ADD, 0001 SUB, 0010 AND, 0011 NOR, 0100 OR, 0101 SLT, 0110 BEQ, 0111 BNE; 1000-1111 illegal
op_a  in  WIDTH  operand A (rs)
op_b  in  WIDTH  operand B (rt or sign-extended immediate)
store_data_in  in  WIDTH  rt value for stores
rd_in  in  5  destination register number
reg_write_in, mem_read_in, mem_write_in  in  1 each  ID/EX control bits
branch_target_in  in  32  precomputed branch target
stall  in  1  hold EX/MEM register
flush  in  1  insert bubble into EX/MEM
out_valid  out  1  EX/MEM slot valid
result  out  WIDTH  registered ALU result
store_data_out  out  WIDTH  registered store data
rd_out  out  5  registered destination
reg_write_out, mem_read_out, mem_write_out  out  1 each  registered, qualified control bits
zero_out  out  1  registered result==0
overflow_out  out  1  registered signed overflow (ADD/SUB only)
branch_taken  out  1  one-cycle pulse, taken BEQ/BNE
branch_target_out  out  32  target, valid while branch_taken=1
illegal_op  out  1  one-cycle pulse, valid instruction with illegal code
instr_count  out  CNT_W  valid instructions captured, saturating
branch_count  out  CNT_W  taken branches, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0, including both counters.
- Latency is 1 cycle. The instruction presented in cycle N appears on the outputs after edge N+1.
- Priority per edge is flush > stall > capture.
- flush=1: out_valid, reg_write_out, mem_read_out, mem_write_out, branch_taken and illegal_op go to 0. Data fields go to 0. Counters do not increment.
- stall=1 (no flush): all registered outputs hold, except branch_taken and illegal_op, which clear to 0 (pulses never repeat). Counters hold.
- Capture with in_valid=0: same as flush (bubble).
- Capture with in_valid=1:
  - out_valid=1; rd_out and store_data_out are copied.
  - ADD/SUB: wrap modulo 2^WIDTH.
  - overflow_out = signed overflow for ADD/SUB, else 0.
  - AND/OR/NOR: bitwise.
  - SLT: signed compare, result 1 or 0.
  - BEQ/BNE: result = op_a - op_b. reg_write_out, mem_read_out and mem_write_out are forced to 0. branch_taken = zero (BEQ) or !zero (BNE). branch_target_out = branch_target_in when taken, else 0.
  - Illegal code: result=0, all write/mem controls forced to 0, illegal_op=1, out_valid=1.
  - zero_out = (result==0) for all codes.
- Counters:
  - instr_count +1 on each valid capture.
  - branch_count +1 when branch_taken is set.
  - Both saturate at all-ones and never wrap.
- Redirect: the block only reports branch_taken. The hazard unit drives flush for younger instructions; no internal self-kill.
- Reset mid-stall or mid-branch clears everything immediately. The first capture after reset release is treated normally.

Decomposition:
- Shared package alu_pkg: 4-bit ALU code constants (ALU_ADD through ALU_BNE), an is_branch helper, and the illegal-range boundary (code >= 4'b1000).
- One combinational sub-module, alu_core: (alu_ctrl, op_a, op_b) -> (result, zero, overflow, illegal).
- ex_alu_stage contains the EX/MEM register, the stall/flush logic, pulse generation and the counters.

Test Plan:
- ADD op_a=0x7FFFFFFF, op_b=1, in_valid=1 -> next cycle result=0x80000000, overflow_out=1, zero_out=0, instr_count=1.
- SLT op_a=0xFFFFFFFF (-1), op_b=1 -> result=1. SUB with equal operands 5,5 -> result=0, zero_out=1, overflow_out=0.
- BEQ op_a=op_b=0x10, branch_target_in=0x400 -> branch_taken=1 for exactly one cycle, branch_target_out=0x400, reg_write_out=0, branch_count=1. BNE with the same operands -> branch_taken=0.
- Stall asserted for 3 cycles after a taken BEQ -> result, rd_out and out_valid hold; branch_taken=0 during the stall; branch_count stays 1.
- flush and stall both high while in_valid=1 ADD is presented -> out_valid=0, reg_write_out=0, counters unchanged. alu_ctrl=4'b1010 with in_valid=1 -> illegal_op pulse, result=0, reg_write_out=0.
- rst_n dropped asynchronously mid-cycle with counters at 7 -> all outputs 0 immediately, without waiting for a clock edge. Preload instr_count at all-ones and capture a valid instruction -> count stays all-ones.
